// File: rtl/avr_fetch_unit.sv
// Instruction prefetch queue between AVR program flash (1-cycle read latency) and the core.
// Optional build macro: AVR_FETCH_BYTESWAP_EN swaps the bytes of each flash word before queuing.
module avr_fetch_unit #(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] flash_addr,
    output logic              flash_rd,
    input  logic [15:0]       flash_data,
    input  logic              redirect,
    input  logic [15:0]       redirect_pc,
    output logic              instr_valid,
    output logic [15:0]       instr_word,
    output logic [15:0]       instr_next,
    output logic              instr_next_valid,
    output logic [15:0]       instr_pc,
    input  logic              consume,
    input  logic              consume_two
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    typedef enum logic [0:0] {
        ST_STREAM = 1'b0,
        ST_FLUSH  = 1'b1
    } state_t;

    function automatic logic [15:0] swap_bytes(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

    state_t              state_r, state_next_s;
    logic [ADDR_W-1:0]   fetch_pc_r;
    logic [ADDR_W-1:0]   resp_pc_r;
    logic                inflight_r;
    logic [PTR_W-1:0]    head_r, tail_r, next_ptr_s, pop_ptr_s;
    logic [CNT_W-1:0]    count_r;
    logic [OCC_W-1:0]    occ_s;
    logic [15:0]         q_word_r [DEPTH];
    logic [ADDR_W-1:0]   q_pc_r   [DEPTH];
    logic                issue_s, push_s;
    logic [1:0]          pop_cnt_s;
    logic [15:0]         store_word_s;

`ifdef AVR_FETCH_BYTESWAP_EN
    assign store_word_s = swap_bytes(flash_data);
`else
    assign store_word_s = flash_data;
`endif

    // Issue, push and pop decisions; redirect overrides everything this cycle.
    always_comb begin
        issue_s   = 1'b0;
        push_s    = 1'b0;
        pop_cnt_s = 2'd0;
        occ_s     = OCC_W'(count_r) + OCC_W'(inflight_r);
        if (rst_n && !redirect && (occ_s < OCC_W'(DEPTH))) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        if (inflight_r && !redirect) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if (!redirect && consume) begin
            if (consume_two) begin
                pop_cnt_s = instr_next_valid ? 2'd2 : 2'd0;
            end else begin
                pop_cnt_s = instr_valid ? 2'd1 : 2'd0;
            end
        end else begin
            pop_cnt_s = 2'd0;
        end
        pop_ptr_s  = PTR_W'(pop_cnt_s);
        next_ptr_s = head_r + PTR_W'(1);
    end

    // Next-state logic: a redirect always lands in FLUSH, FLUSH lasts one cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_STREAM: state_next_s = redirect ? ST_FLUSH : ST_STREAM;
            ST_FLUSH:  state_next_s = redirect ? ST_FLUSH : ST_STREAM;
            default:   state_next_s = ST_STREAM;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_STREAM;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Fetch PC, in-flight tracking and queue pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r <= '0;
            resp_pc_r  <= '0;
            inflight_r <= 1'b0;
            head_r     <= '0;
            tail_r     <= '0;
            count_r    <= '0;
        end else if (redirect) begin
            // The response arriving this cycle belongs to the old stream and is dropped.
            fetch_pc_r <= redirect_pc[ADDR_W-1:0];
            inflight_r <= 1'b0;
            head_r     <= '0;
            tail_r     <= '0;
            count_r    <= '0;
        end else begin
            if (issue_s) begin
                fetch_pc_r <= fetch_pc_r + ADDR_W'(1);
                resp_pc_r  <= fetch_pc_r;
            end
            inflight_r <= issue_s;
            if (push_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            head_r  <= head_r + pop_ptr_s;
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_cnt_s);
        end
    end

    // Queue storage: word and its PC written at the tail on each accepted response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_word_r[i] <= 16'h0000;
                q_pc_r[i]   <= '0;
            end
        end else if (push_s) begin
            q_word_r[tail_r] <= store_word_s;
            q_pc_r[tail_r]   <= resp_pc_r;
        end
    end

    assign flash_rd   = issue_s;
    assign flash_addr = fetch_pc_r;

    // Head/next views of the queue, forced to zero when the entry is absent.
    always_comb begin
        instr_valid      = (count_r != CNT_W'(0));
        instr_next_valid = (count_r >= CNT_W'(2));
        instr_word       = 16'h0000;
        instr_next       = 16'h0000;
        instr_pc         = 16'h0000;
        if (instr_valid) begin
            instr_word = q_word_r[head_r];
            instr_pc   = 16'(q_pc_r[head_r]);
        end else begin
            instr_word = 16'h0000;
            instr_pc   = 16'h0000;
        end
        if (instr_next_valid) begin
            instr_next = q_word_r[next_ptr_s];
        end else begin
            instr_next = 16'h0000;
        end
    end

endmodule

// File: tb/tb_avr_fetch_unit.sv
// Directed testbench for avr_fetch_unit with a one-cycle-latency flash model.
module tb_avr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] flash_addr;
    logic        flash_rd;
    logic [15:0] flash_data = 16'h0000;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic [15:0] instr_word;
    logic [15:0] instr_next;
    logic        instr_next_valid;
    logic [15:0] instr_pc;
    logic        consume;
    logic        consume_two;

    int compared   = 0;
    int mismatched = 0;
    int nreads     = 0;

    avr_fetch_unit #(.ADDR_W(14), .DEPTH(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flash_addr       (flash_addr),
        .flash_rd         (flash_rd),
        .flash_data       (flash_data),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .instr_valid      (instr_valid),
        .instr_word       (instr_word),
        .instr_next       (instr_next),
        .instr_next_valid (instr_next_valid),
        .instr_pc         (instr_pc),
        .consume          (consume),
        .consume_two      (consume_two)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] flash_word(input logic [13:0] a);
        return (a == 14'd0) ? 16'h0FE5 : (16'hA000 | {2'b00, a});
    endfunction

    function automatic logic [15:0] exp_word(input logic [13:0] a);
        logic [15:0] w;
        w = flash_word(a);
`ifdef AVR_FETCH_BYTESWAP_EN
        return {w[7:0], w[15:8]};
`else
        return w;
`endif
    endfunction

    // Flash: data for the address sampled at an edge is valid during the following cycle.
    always @(posedge clk) begin
        if (flash_rd) flash_data <= flash_word(flash_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        consume = 1'b0; consume_two = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_rd",    32'(flash_rd), 32'd0);
        chk("rst_addr",  32'(flash_addr), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_nval",  32'(instr_next_valid), 32'd0);
        chk("rst_word",  32'(instr_word), 32'd0);
        chk("rst_next",  32'(instr_next), 32'd0);
        chk("rst_pc",    32'(instr_pc), 32'd0);
        tick();
        rst_n = 1'b1;

        // Cycles 0..5: reads 0..3, then stall with a full queue.
        for (int c = 0; c < 6; c++) begin
            #2;
            chk("fill_rd", 32'(flash_rd), 32'(c < 4));
            if (c < 4) chk("fill_addr", 32'(flash_addr), 32'(c));
            chk("fill_valid", 32'(instr_valid), 32'(c >= 2));
            if (c == 2) begin
                chk("first_pc",   32'(instr_pc), 32'd0);
                chk("first_word", 32'(instr_word), 32'(exp_word(14'd0)));
            end
            tick();
        end

        // Cycle 6: full queue 0..3, pop two.
        consume = 1'b1; consume_two = 1'b1;
        #2;
        chk("full_nval", 32'(instr_next_valid), 32'd1);
        chk("full_next", 32'(instr_next), 32'(exp_word(14'd1)));
        chk("full_rd",   32'(flash_rd), 32'd0);
        tick();
        consume = 1'b0; consume_two = 1'b0;
        #2;
        chk("pop2_pc",   32'(instr_pc), 32'd2);
        chk("pop2_addr", 32'(flash_addr), 32'd4);
        chk("pop2_rd",   32'(flash_rd), 32'd1);
        repeat (3) tick();
        // Cycle 10: queue 2..5, pop two again to reach 4..7.
        consume = 1'b1; consume_two = 1'b1;
        tick();
        consume = 1'b0; consume_two = 1'b0;
        repeat (3) tick();
        // Cycle 14: queue full at 4..7.
        #2;
        chk("q47_pc", 32'(instr_pc), 32'd4);
        chk("q47_rd", 32'(flash_rd), 32'd0);
        consume = 1'b1; consume_two = 1'b1;
        tick();
        consume = 1'b0; consume_two = 1'b0;
        #2;
        chk("q47_pop_pc", 32'(instr_pc), 32'd6);
        for (int i = 0; i < 4; i++) begin
            #1;
            if (flash_rd) begin
                chk("refill_addr", 32'(flash_addr), 32'(8 + nreads));
                nreads++;
            end
            tick();
        end
        chk("refill_count", 32'(nreads), 32'd2);

        // Cycle 19: single pop so read 10 goes out, then redirect while it is in flight.
        consume = 1'b1;
        tick();
        consume = 1'b0;
        #2;
        chk("pre_redir_addr", 32'(flash_addr), 32'd10);
        tick();
        redirect = 1'b1; redirect_pc = 16'h0123; consume = 1'b1;
        #2;
        chk("redir_rd", 32'(flash_rd), 32'd0);
        tick();
        redirect = 1'b0; consume = 1'b0;
        #2;
        chk("flush_valid", 32'(instr_valid), 32'd0);
        chk("flush_addr",  32'(flash_addr), 32'h123);
        chk("flush_rd",    32'(flash_rd), 32'd1);
        tick();
        #2;
        chk("redir_addr2",  32'(flash_addr), 32'h124);
        chk("redir_valid2", 32'(instr_valid), 32'd0);
        tick();
        // One entry present: consume_two must be ignored.
        consume = 1'b1; consume_two = 1'b1;
        #2;
        chk("redir_pc",   32'(instr_pc), 32'h123);
        chk("redir_word", 32'(instr_word), 32'(exp_word(14'h123)));
        chk("lone_nval",  32'(instr_next_valid), 32'd0);
        chk("lone_next",  32'(instr_next), 32'd0);
        tick();
        consume_two = 1'b0;
        #2;
        chk("ign2_pc",   32'(instr_pc), 32'h123);
        chk("ign2_next", 32'(instr_next), 32'(exp_word(14'h124)));

        // Steady single consume: PC advances every cycle with no bubbles.
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("stream_valid", 32'(instr_valid), 32'd1);
            chk("stream_pc",    32'(instr_pc), 32'(16'h0123 + i));
            tick();
        end
        consume = 1'b0;

        // Redirect near the top of the address space: fetch wraps to 0.
        redirect = 1'b1; redirect_pc = 16'h3FFE;
        tick();
        redirect = 1'b0;
        #2;
        chk("wrap_addr0", 32'(flash_addr), 32'h3FFE);
        tick();
        #2;
        chk("wrap_addr1", 32'(flash_addr), 32'h3FFF);
        tick();
        #2;
        chk("wrap_addr2", 32'(flash_addr), 32'h0000);
        chk("wrap_rd2",   32'(flash_rd), 32'd1);
        chk("wrap_pc0",   32'(instr_pc), 32'h3FFE);
        repeat (2) tick();
        consume = 1'b1; consume_two = 1'b1;
        #2;
        chk("wrap_next", 32'(instr_next), 32'(exp_word(14'h3FFF)));
        tick();
        consume = 1'b0; consume_two = 1'b0;
        #2;
        chk("wrap_pc2",   32'(instr_pc), 32'd0);
        chk("wrap_word2", 32'(instr_word), 32'(exp_word(14'd0)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
